ball_motion: RTL

//   Producer of ball position for the pong renderer: owns ball centre coordinates and direction.

---
 rtl/pong_pkg.sv | 19 +
 rtl/ball_collision.sv | 98 +++++++++
 rtl/ball_motion.sv | 118 +++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong ball datapath.
// Latency: n/a (types only); no backpressure.
package pong_pkg;

    typedef logic [11:0] coord_t;
    typedef logic [12:0] wide_t;

    localparam logic [1:0] UP_LEFT    = 2'b00;
    localparam logic [1:0] DOWN_LEFT  = 2'b01;
    localparam logic [1:0] UP_RIGHT   = 2'b10;
    localparam logic [1:0] DOWN_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SCORED = 2'd2
    } state_t;

endpackage

// File: rtl/ball_collision.sv
// One frame step of the ball: wall bounces, paddle bounces and miss detection.
// Latency: combinational; no backpressure (sampled by the owner on frame_tick).
module ball_collision
    import pong_pkg::*;
#(
    parameter int DISP_COLS     = 640,
    parameter int DISP_ROWS     = 480,
    parameter int BALL_HEIGHT   = 8,
    parameter int BALL_WIDTH    = 6,
    parameter int PADDLE_HEIGHT = 48,
    parameter int PADDLE_WIDTH  = 8,
    parameter int L_PADDLE_COL  = 16,
    parameter int R_PADDLE_COL  = 616,
    parameter int BALL_SPEED    = 2
) (
    input  logic [11:0] row,
    input  logic [11:0] col,
    input  logic [1:0]  dir,
    input  logic [11:0] l_paddle_row,
    input  logic [11:0] r_paddle_row,
    output logic [11:0] nxt_row,
    output logic [11:0] nxt_col,
    output logic [1:0]  nxt_dir,
    output logic        l_miss,
    output logic        r_miss
);

    localparam coord_t SPEED   = coord_t'(BALL_SPEED);
    localparam coord_t TOP_ROW = coord_t'(BALL_HEIGHT / 2);
    localparam coord_t TOP_LIM = coord_t'(BALL_HEIGHT / 2 + BALL_SPEED);
    localparam coord_t BOT_ROW = coord_t'(DISP_ROWS - 1 - BALL_HEIGHT / 2);
    localparam wide_t  ROW_MAX = wide_t'(DISP_ROWS - 1);
    localparam wide_t  V_REACH = wide_t'(BALL_SPEED + BALL_HEIGHT / 2);
    localparam coord_t REACH   = coord_t'((BALL_HEIGHT + PADDLE_HEIGHT) / 2);
    // Left-edge tests rewritten onto the centre column: col > face + half-width, etc.
    localparam coord_t L_NEAR  = coord_t'(L_PADDLE_COL + PADDLE_WIDTH - 1 + BALL_WIDTH / 2);
    localparam coord_t L_FAR   = coord_t'(L_PADDLE_COL + PADDLE_WIDTH - 1 + BALL_WIDTH / 2 + BALL_SPEED);
    localparam coord_t L_BOUNCE = coord_t'(L_PADDLE_COL + PADDLE_WIDTH + BALL_WIDTH / 2);
    localparam coord_t L_MISS  = coord_t'(BALL_WIDTH / 2 + BALL_SPEED);
    localparam wide_t  HALF_W  = wide_t'(BALL_WIDTH / 2);
    localparam wide_t  H_REACH = wide_t'(BALL_SPEED + BALL_WIDTH / 2);
    localparam wide_t  R_FACE  = wide_t'(R_PADDLE_COL);
    localparam coord_t R_BOUNCE = coord_t'(R_PADDLE_COL - 1 - BALL_WIDTH / 2);
    localparam wide_t  COL_MAX = wide_t'(DISP_COLS - 1);
    localparam coord_t CEN_ROW = coord_t'(DISP_ROWS / 2);
    localparam coord_t CEN_COL = coord_t'(DISP_COLS / 2);

    logic   down;
    logic   right;
    logic   l_hit;
    logic   r_hit;
    coord_t l_dist;
    coord_t r_dist;

    always_comb begin
        down    = dir[0];
        right   = dir[1];
        l_dist  = (row >= l_paddle_row) ? row - l_paddle_row : l_paddle_row - row;
        r_dist  = (row >= r_paddle_row) ? row - r_paddle_row : r_paddle_row - row;

        l_hit   = !right && (col > L_NEAR) && (col <= L_FAR) && (l_dist <= REACH);
        r_hit   = right && ((wide_t'(col) + HALF_W) < R_FACE)
                        && ((wide_t'(col) + H_REACH) >= R_FACE) && (r_dist <= REACH);
        l_miss  = !right && !l_hit && (col < L_MISS);
        r_miss  = right && !r_hit && ((wide_t'(col) + H_REACH) > COL_MAX);

        nxt_dir = dir;
        nxt_row = row;
        nxt_col = col;

        if (!down && (row < TOP_LIM)) begin
            nxt_row    = TOP_ROW;
            nxt_dir[0] = 1'b1;
        end else if (down && ((wide_t'(row) + V_REACH) > ROW_MAX)) begin
            nxt_row    = BOT_ROW;
            nxt_dir[0] = 1'b0;
        end else begin
            nxt_row = down ? row + SPEED : row - SPEED;
        end

        if (l_hit) begin
            nxt_col    = L_BOUNCE;
            nxt_dir[1] = 1'b1;
        end else if (r_hit) begin
            nxt_col    = R_BOUNCE;
            nxt_dir[1] = 1'b0;
        end else begin
            nxt_col = right ? col + SPEED : col - SPEED;
        end

        // A miss keeps the horizontal bit, so the re-serve heads toward the side that conceded.
        if (l_miss || r_miss) begin
            nxt_row = CEN_ROW;
            nxt_col = CEN_COL;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball position owner for pong: serve/move/score FSM with re-serve delay, advanced per frame.
// Latency: outputs update 1 cycle after frame_tick; no backpressure (one step per tick).
module ball_motion
    import pong_pkg::*;
#(
    parameter int DISP_COLS     = 640,
    parameter int DISP_ROWS     = 480,
    parameter int BALL_HEIGHT   = 8,
    parameter int BALL_WIDTH    = 6,
    parameter int PADDLE_HEIGHT = 48,
    parameter int PADDLE_WIDTH  = 8,
    parameter int L_PADDLE_COL  = 16,
    parameter int R_PADDLE_COL  = 616,
    parameter int BALL_SPEED    = 2,
    parameter int SERVE_DELAY   = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [11:0] l_paddle_row,
    input  logic [11:0] r_paddle_row,
    output logic [11:0] ball_center_row,
    output logic [11:0] ball_center_col,
    output logic [1:0]  ball_direction,
    output logic        ball_active,
    output logic        score_left,
    output logic        score_right
);

    localparam int     CNT_W   = $clog2(SERVE_DELAY + 1);
    localparam coord_t CEN_ROW = coord_t'(DISP_ROWS / 2);
    localparam coord_t CEN_COL = coord_t'(DISP_COLS / 2);

    state_t            state;
    logic [CNT_W-1:0]  delay_cnt;
    coord_t            nxt_row;
    coord_t            nxt_col;
    logic [1:0]        nxt_dir;
    logic              l_miss;
    logic              r_miss;

    ball_collision #(
        .DISP_COLS     (DISP_COLS),
        .DISP_ROWS     (DISP_ROWS),
        .BALL_HEIGHT   (BALL_HEIGHT),
        .BALL_WIDTH    (BALL_WIDTH),
        .PADDLE_HEIGHT (PADDLE_HEIGHT),
        .PADDLE_WIDTH  (PADDLE_WIDTH),
        .L_PADDLE_COL  (L_PADDLE_COL),
        .R_PADDLE_COL  (R_PADDLE_COL),
        .BALL_SPEED    (BALL_SPEED)
    ) u_collision (
        .row          (ball_center_row),
        .col          (ball_center_col),
        .dir          (ball_direction),
        .l_paddle_row (l_paddle_row),
        .r_paddle_row (r_paddle_row),
        .nxt_row      (nxt_row),
        .nxt_col      (nxt_col),
        .nxt_dir      (nxt_dir),
        .l_miss       (l_miss),
        .r_miss       (r_miss)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ball_center_row <= CEN_ROW;
            ball_center_col <= CEN_COL;
            ball_direction  <= DOWN_RIGHT;
            ball_active     <= 1'b0;
            score_left      <= 1'b0;
            score_right     <= 1'b0;
            delay_cnt       <= '0;
        end else begin
            score_left  <= 1'b0;
            score_right <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve) begin
                        state       <= MOVE;
                        ball_active <= 1'b1;
                    end
                end
                MOVE: begin
                    if (frame_tick) begin
                        ball_center_row <= nxt_row;
                        ball_center_col <= nxt_col;
                        ball_direction  <= nxt_dir;
                        if (l_miss || r_miss) begin
                            state       <= SCORED;
                            ball_active <= 1'b0;
                            score_right <= l_miss;
                            score_left  <= r_miss;
                        end
                    end
                end
                SCORED: begin
                    if (frame_tick) begin
                        if (delay_cnt == CNT_W'(SERVE_DELAY - 1)) begin
                            delay_cnt   <= '0;
                            state       <= MOVE;
                            ball_active <= 1'b1;
                        end else begin
                            delay_cnt <= delay_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    ball_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
